// File: rtl/ca_dispatch_pkg.sv
// ca_dispatch shared definitions: command field layout, output FSM encoding,
// statistics counter width and a saturating-increment helper.
package ca_dispatch_pkg;

    localparam int CMD_W   = 32;
    localparam int TID_MSB = 31;
    localparam int TID_LSB = 28;
    localparam int TID_W   = TID_MSB - TID_LSB + 1;
    localparam int PAY_MSB = 27;
    localparam int PAY_LSB = 0;
    localparam int PAY_W   = PAY_MSB - PAY_LSB + 1;
    localparam int STAT_W  = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } disp_state_t;

    function automatic logic [TID_W-1:0] cmd_tid(input logic [CMD_W-1:0] c);
        return c[TID_MSB:TID_LSB];
    endfunction

    function automatic logic [PAY_W-1:0] cmd_payload(input logic [CMD_W-1:0] c);
        return c[PAY_MSB:PAY_LSB];
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/ca_dispatch_if.sv
// ca_dispatch bus: calendar-side command strobe/back-pressure, flush, and the
// valid/ready event channel to the thread controller.
// master = calendar + thread controller side, slave = ca_dispatch.
interface ca_dispatch_if;

    logic                                   ca_match;
    logic [ca_dispatch_pkg::CMD_W-1:0]      ca_command;
    logic                                   ca_match_block;
    logic                                   flush;
    logic                                   tc_ev_valid;
    logic [ca_dispatch_pkg::TID_W-1:0]      tc_ev_tid;
    logic [ca_dispatch_pkg::PAY_W-1:0]      tc_ev_data;
    logic                                   tc_ev_ready;
    logic                                   ev_drop;

    modport master (
        output ca_match, ca_command, flush, tc_ev_ready,
        input  ca_match_block, tc_ev_valid, tc_ev_tid, tc_ev_data, ev_drop
    );

    modport slave (
        input  ca_match, ca_command, flush, tc_ev_ready,
        output ca_match_block, tc_ev_valid, tc_ev_tid, tc_ev_data, ev_drop
    );

endinterface

// File: rtl/ca_dispatch_fifo.sv
// ca_dispatch command buffer: power-of-two circular FIFO, pointers wrap
// naturally at AW bits, count is AW+1 bits so "full" is representable.
// Push while full / pop while empty are ignored; flush wins over both.
module ca_dispatch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_C = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == FULL_C);
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = mem[rd_ptr];

    // storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ca_dispatch.sv
// ca_dispatch: accepts calendar match commands, drops those aimed at
// non-existent threads, buffers the rest and offers them one at a time to the
// thread controller over a valid/ready channel.
// Optional: define CA_DISPATCH_STATS_EN to add saturating stat_disp /
// stat_drop / stat_block counters.
module ca_dispatch
    import ca_dispatch_pkg::*;
#(
    parameter int NUM_THREADS = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rstn,
    ca_dispatch_if.slave       bus
`ifdef CA_DISPATCH_STATS_EN
    ,
    output logic [STAT_W-1:0]  stat_disp,
    output logic [STAT_W-1:0]  stat_drop,
    output logic [STAT_W-1:0]  stat_block
`endif
);

    localparam int                CW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]     FULL_C = FIFO_DEPTH[CW-1:0];
    localparam logic [TID_W:0]    NT_C   = NUM_THREADS[TID_W:0];

    disp_state_t        state, state_nx;
    logic               block, accept, tid_ok, push, pop;
    logic               fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [CMD_W-1:0]   fifo_dout;
    logic [TID_W-1:0]   ev_tid;
    logic [PAY_W-1:0]   ev_data;
    logic               ev_valid;
    logic               drop_r;

    // Block only from occupancy and flush, so a repeated strobe is accepted once.
    assign block    = (fifo_count == FULL_C) | bus.flush;
    assign accept   = bus.ca_match & ~block;
    assign tid_ok   = ({1'b0, cmd_tid(bus.ca_command)} < NT_C);
    assign push     = accept & tid_ok & ~fifo_full;
    assign ev_valid = (state == ST_OFFER);

    assign bus.ca_match_block = block;
    assign bus.tc_ev_valid    = ev_valid;
    assign bus.tc_ev_tid      = ev_tid;
    assign bus.tc_ev_data     = ev_data;
    assign bus.ev_drop        = drop_r;

    ca_dispatch_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (bus.flush),
        .din   (bus.ca_command),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // output FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // next state and head pop: reload whenever the output slot is free or being taken
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (bus.tc_ev_ready) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_nx = ST_IDLE;
            pop      = 1'b0;
        end
    end

    // output register: loads on pop, otherwise holds stable while offered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ev_tid  <= '0;
            ev_data <= '0;
        end else if (bus.flush) begin
            ev_tid  <= '0;
            ev_data <= '0;
        end else if (pop) begin
            ev_tid  <= cmd_tid(fifo_dout);
            ev_data <= cmd_payload(fifo_dout);
        end
    end

    // one-cycle drop pulse for an accepted command with an out-of-range tid
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) drop_r <= 1'b0;
        else       drop_r <= accept & ~tid_ok;
    end

`ifdef CA_DISPATCH_STATS_EN
    // saturating statistics, cleared only by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_disp  <= '0;
            stat_drop  <= '0;
            stat_block <= '0;
        end else begin
            stat_disp  <= sat_inc(stat_disp,  ev_valid & bus.tc_ev_ready);
            stat_drop  <= sat_inc(stat_drop,  drop_r);
            stat_block <= sat_inc(stat_block, bus.ca_match & block);
        end
    end
`endif

endmodule

// File: tb/tb_ca_dispatch.sv
// Self-checking bench for ca_dispatch. Two instances share one stimulus:
// u_dut16 (NUM_THREADS=16) for ordering/flush/reset sequences and u_dut6
// (NUM_THREADS=6) for drop vectors and a randomized run against a
// transaction-level queue model.
module tb_ca_dispatch;
    import ca_dispatch_pkg::*;

    localparam int DEPTH = 4;
    localparam int NT6   = 6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ca_match = 1'b0;
    logic        flush = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] cmd = '0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ca_dispatch_if a_if();
    ca_dispatch_if b_if();

    assign a_if.ca_match    = ca_match;
    assign a_if.ca_command  = cmd;
    assign a_if.flush       = flush;
    assign a_if.tc_ev_ready = ready;
    assign b_if.ca_match    = ca_match;
    assign b_if.ca_command  = cmd;
    assign b_if.flush       = flush;
    assign b_if.tc_ev_ready = ready;

`ifdef CA_DISPATCH_STATS_EN
    logic [15:0] a_disp, a_drop, a_blk, b_disp, b_drop, b_blk;
`endif

    ca_dispatch #(.NUM_THREADS(16), .FIFO_DEPTH(DEPTH)) u_dut16 (
        .clk (clk), .rstn (rstn), .bus (a_if)
`ifdef CA_DISPATCH_STATS_EN
        , .stat_disp (a_disp), .stat_drop (a_drop), .stat_block (a_blk)
`endif
    );

    ca_dispatch #(.NUM_THREADS(NT6), .FIFO_DEPTH(DEPTH)) u_dut6 (
        .clk (clk), .rstn (rstn), .bus (b_if)
`ifdef CA_DISPATCH_STATS_EN
        , .stat_disp (b_disp), .stat_drop (b_drop), .stat_block (b_blk)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        ca_match = 1'b0; flush = 1'b0; ready = 1'b0; cmd = '0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [31:0] cmd;
        logic        exp_v;
        logic [3:0]  exp_tid;
        logic [27:0] exp_data;
        logic        exp_drop;
    } vec_t;

    vec_t        vt[5];
    int          exp_drops;
    int          k, got, cyc;
    // reference model state for the random run
    logic [31:0] mq[$];
    logic        m_off_v, m_drop_p, m_blk, m_acc;
    logic [31:0] m_off;
    int          m_disp, m_drop, m_blkcnt;

    initial begin
        // ---------------- reset values ----------------
        #3;
        chk("rst valid", a_if.tc_ev_valid, 0);
        chk("rst tid",   a_if.tc_ev_tid, 0);
        chk("rst data",  a_if.tc_ev_data, 0);
        chk("rst block", a_if.ca_match_block, 0);
        chk("rst drop",  a_if.ev_drop, 0);

        // ---------------- single-command vectors on NUM_THREADS=6 ----------------
        vt[0] = '{32'h3000_00AB, 1'b1, 4'h3, 28'h00000AB, 1'b0};
        vt[1] = '{32'hF000_0001, 1'b0, 4'h0, 28'h0,       1'b1};
        vt[2] = '{32'h5FFF_FFFF, 1'b1, 4'h5, 28'hFFFFFFF, 1'b0};
        vt[3] = '{32'h6000_0002, 1'b0, 4'h0, 28'h0,       1'b1};
        vt[4] = '{32'h0000_0000, 1'b1, 4'h0, 28'h0,       1'b0};
        do_reset();
        ready = 1'b1;
        exp_drops = 0;
        foreach (vt[i]) begin
            cmd = vt[i].cmd; ca_match = 1'b1; settle();
            chk("vec block", b_if.ca_match_block, 0);
            tick(); ca_match = 1'b0; settle();
            chk("vec valid N+1", b_if.tc_ev_valid, 0);
            chk("vec drop N+1",  b_if.ev_drop, vt[i].exp_drop);
            tick(); settle();
            chk("vec valid N+2", b_if.tc_ev_valid, vt[i].exp_v);
            if (vt[i].exp_v) begin
                chk("vec tid",  b_if.tc_ev_tid, vt[i].exp_tid);
                chk("vec data", b_if.tc_ev_data, vt[i].exp_data);
            end
            tick(); settle();
            chk("vec valid N+3", b_if.tc_ev_valid, 0);
            chk("vec drop N+3",  b_if.ev_drop, 0);
            if (vt[i].exp_drop) exp_drops++;
        end
`ifdef CA_DISPATCH_STATS_EN
        chk("stat_drop vec", b_drop, exp_drops);
`endif

        // ---------------- fill, block, duplicate strobes, drain ----------------
        do_reset();
        ready = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            ca_match = 1'b1; cmd = {4'(j), 28'(j + 'h100)};
            tick();
        end
        cmd = 32'h7000_0077;
        for (int j = 0; j < 10; j++) begin
            settle();
            chk("hold block", a_if.ca_match_block, 1);
            chk("hold valid", a_if.tc_ev_valid, 1);
            chk("hold tid",   a_if.tc_ev_tid, 1);
            chk("hold data",  a_if.tc_ev_data, 'h101);
            tick();
        end
        ca_match = 1'b0; ready = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            settle();
            chk("drain valid", a_if.tc_ev_valid, 1);
            chk("drain tid",   a_if.tc_ev_tid, j);
            chk("drain data",  a_if.tc_ev_data, j + 'h100);
            tick();
        end
        settle();
        chk("drain done", a_if.tc_ev_valid, 0);

        // ---------------- flush during offer ----------------
        do_reset();
        ready = 1'b0;
        for (int j = 8; j < 12; j++) begin
            ca_match = 1'b1; cmd = {4'(j), 28'(j)};
            tick();
        end
        ca_match = 1'b0; settle();
        chk("pre-flush valid", a_if.tc_ev_valid, 1);
        flush = 1'b1; settle();
        chk("flush block", a_if.ca_match_block, 1);
        tick(); flush = 1'b0; settle();
        chk("post-flush valid", a_if.tc_ev_valid, 0);
        chk("post-flush block", a_if.ca_match_block, 0);
        cmd = 32'h1000_0005; ca_match = 1'b1; ready = 1'b1;
        tick(); ca_match = 1'b0; settle();
        chk("flush N+1 valid", a_if.tc_ev_valid, 0);
        tick(); settle();
        chk("flush N+2 valid", a_if.tc_ev_valid, 1);
        chk("flush N+2 tid",   a_if.tc_ev_tid, 1);
        chk("flush N+2 data",  a_if.tc_ev_data, 5);
        tick(); settle();
        chk("flush empty", a_if.tc_ev_valid, 0);

        // ---------------- continuous stream, ready toggling ----------------
        do_reset();
        k = 0; got = 0; cyc = 0;
        while ((got < 16) && (cyc < 400)) begin
            ca_match = (k < 16);
            cmd      = {4'(k), 28'(k * 3 + 7)};
            ready    = cyc[0];
            settle();
            if (a_if.tc_ev_valid && ready) begin
                chk("seq tid",  a_if.tc_ev_tid, got);
                chk("seq data", a_if.tc_ev_data, got * 3 + 7);
                got++;
            end
            if (ca_match && !a_if.ca_match_block) k++;
            tick();
            cyc++;
        end
        ca_match = 1'b0; ready = 1'b1;
        chk("seq accepted", k, 16);
        chk("seq delivered", got, 16);
        settle();
        chk("seq no extra", a_if.tc_ev_valid, 0);

        // ---------------- reset during offer ----------------
        do_reset();
        ready = 1'b0;
        for (int j = 2; j < 5; j++) begin
            ca_match = 1'b1; cmd = {4'(j), 28'(j)};
            tick();
        end
        ca_match = 1'b0; settle();
        chk("pre-rst valid", a_if.tc_ev_valid, 1);
        #2 rstn = 1'b0; #1;
        chk("mid-rst valid", a_if.tc_ev_valid, 0);
        chk("mid-rst tid",   a_if.tc_ev_tid, 0);
        chk("mid-rst data",  a_if.tc_ev_data, 0);
        chk("mid-rst block", a_if.ca_match_block, 0);
        chk("mid-rst drop",  a_if.ev_drop, 0);
        tick(); rstn = 1'b1; ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            settle();
            chk("post-rst stale", a_if.tc_ev_valid, 0);
            tick();
        end

        // ---------------- randomized run vs queue model (NUM_THREADS=6) ----------------
        do_reset();
        mq.delete(); m_off_v = 1'b0; m_off = '0; m_drop_p = 1'b0;
        m_disp = 0; m_drop = 0; m_blkcnt = 0;
        for (int c = 0; c < 400; c++) begin
            ca_match = ($urandom_range(0, 9) < 7);
            cmd      = {4'($urandom_range(0, 15)), 28'($urandom)};
            ready    = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 39) == 0);
            settle();
            m_blk = (mq.size() == DEPTH) || flush;
            chk("rnd block", b_if.ca_match_block, m_blk);
            chk("rnd valid", b_if.tc_ev_valid, m_off_v);
            chk("rnd drop",  b_if.ev_drop, m_drop_p);
            if (m_off_v) begin
                chk("rnd tid",  b_if.tc_ev_tid, m_off[31:28]);
                chk("rnd data", b_if.tc_ev_data, m_off[27:0]);
            end
            if (ca_match && m_blk) m_blkcnt++;
            if (m_drop_p) m_drop++;
            if (m_off_v && ready) m_disp++;
            m_acc = ca_match && !m_blk;
            if (flush) begin
                mq.delete();
                m_off_v = 1'b0;
            end else begin
                if (!m_off_v || ready) begin
                    if (mq.size() > 0) begin
                        m_off   = mq.pop_front();
                        m_off_v = 1'b1;
                    end else begin
                        m_off_v = 1'b0;
                    end
                end
                if (m_acc && (cmd[31:28] < NT6)) mq.push_back(cmd);
            end
            m_drop_p = m_acc && (cmd[31:28] >= NT6);
            tick();
        end
        ca_match = 1'b0; flush = 1'b0; settle();
`ifdef CA_DISPATCH_STATS_EN
        chk("stat_disp rnd",  b_disp, m_disp);
        chk("stat_drop rnd",  b_drop, m_drop);
        chk("stat_block rnd", b_blk,  m_blkcnt);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ca_dispatch.md
CA_DISPATCH -- requirements
Module: ca_dispatch

Interface
REQ-001 Parameter: NUM_THREADS, default 16, number of valid target thread IDs (1..16).
REQ-002 Parameter: FIFO_DEPTH, default 4, command buffer entries; power of 2, 2..16.
REQ-003 Port: clk  in  1  single clock; all state on rising edge.
REQ-004 Port: rstn  in  1  asynchronous active-low reset.
REQ-005 Port: ca_match  in  1  calendar match strobe; repeats each cycle while blocked.
REQ-006 Port: ca_command  in  32  matched command; [31:28] target tid, [27:0] payload.
REQ-007 Port: ca_match_block  out  1  back-pressure to calendar; command held while high.
REQ-008 Port: flush  in  1  synchronous clear of buffer and output stage.
REQ-009 Port: tc_ev_valid  out  1  event offered to thread controller.
REQ-010 Port: tc_ev_tid  out  4  target thread of offered event.
REQ-011 Port: tc_ev_data  out  28  payload of offered event.
REQ-012 Port: tc_ev_ready  in  1  thread controller accepts the event when high together with tc_ev_valid.
REQ-013 Port: ev_drop  out  1  one-cycle pulse, accepted command had tid >= NUM_THREADS.

Function
REQ-014 Accept: a command SHALL be accepted in every cycle with ca_match=1 and ca_match_block=0; cycles with ca_match=1 and ca_match_block=1 SHALL be ignored, so duplicate strobes never double-enqueue.
REQ-015 ca_match_block SHALL equal (fifo count == FIFO_DEPTH) | flush, derived from registered state only.
REQ-016 An accepted command with tid < NUM_THREADS SHALL be pushed to the FIFO; with tid >= NUM_THREADS it SHALL be discarded and ev_drop pulse in the following cycle.
REQ-017 Output FSM states: IDLE (tc_ev_valid=0), OFFER (tc_ev_valid=1, output register holds head event).
REQ-018 IDLE -> OFFER when FIFO non-empty: pop head into output register.
REQ-019 OFFER with tc_ev_ready=1: if FIFO non-empty, pop and reload in the same cycle, stay OFFER; else -> IDLE.
REQ-020 OFFER with tc_ev_ready=0: hold tc_ev_tid/tc_ev_data stable, stay OFFER.
REQ-021 Latency: push in cycle N into empty FIFO with FSM IDLE -> tc_ev_valid=1 in cycle N+2; sustained throughput 1 event/cycle.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; order strictly FIFO.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-024 flush=1 SHALL, next cycle, empty FIFO, force IDLE, drop tc_ev_valid; commands presented during flush are not accepted; flush wins over push/pop.

Reset
REQ-025 On rstn=0: FIFO empty, pointers 0, FSM IDLE, tc_ev_valid=0, tc_ev_tid=0, tc_ev_data=0, ca_match_block=0, ev_drop=0, counters 0.
REQ-026 Reset asserted mid-offer SHALL discard the offered event and all buffered commands without handshake.

Configuration
REQ-027 Macro CA_DISPATCH_STATS_EN defined: adds outputs stat_disp[15:0] (handshakes completed), stat_drop[15:0] (ev_drop pulses), stat_block[15:0] (cycles ca_match & ca_match_block); all saturate at 16'hFFFF, cleared by reset only.
REQ-028 Macro undefined: stat ports and counters absent; all other behaviour identical.

Structure
REQ-029 Shared package SHALL hold the command field positions (tid [31:28], payload [27:0]), FSM state encoding, and stat counter width.
REQ-030 FIFO SHALL be a separate sub-module ca_dispatch_fifo (push, pop, flush, full, empty, count); FSM, drop logic and stats in ca_dispatch.

Verification
REQ-031 Single command 32'h3000_00AB, tc_ev_ready=1 -> tc_ev_valid at N+2, tc_ev_tid=3, tc_ev_data=28'h00000AB, one cycle.
REQ-032 tc_ev_ready=0, 5 commands at FIFO_DEPTH=4 -> 4 accepted (+1 in output reg) ... ca_match_block=1 with count 4; strobes held 10 cycles add nothing; release ready -> 5 events in order, one per cycle.
REQ-033 Command 32'hF000_0001 with NUM_THREADS=6 -> no tc_ev_valid, ev_drop pulses once; stat_drop=1 when CA_DISPATCH_STATS_EN.
REQ-034 FIFO holding 3 events, OFFER, flush for 1 cycle -> next cycle tc_ev_valid=0, count 0, block=0; later command 32'h1000_0005 delivered normally.
REQ-035 Continuous commands tids 0,1,2,...,15 and ready toggling 1/0 -> output sequence 0..15 with no loss or duplicate; pointers wrap ≥3 times.
REQ-036 rstn low during OFFER with 2 buffered -> all outputs at reset values; after release no stale event appears.
